// File: rtl/tx_fifo_if.sv
// Handshake bundle between the byte writer (master) and the TX FIFO (slave).
// Error-flag signals exist only when TX_FIFO_ERR_FLAGS_EN is defined.
interface tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  TxFfWrEn;
    logic [DATA_WIDTH-1:0] TxFfWrData;
    logic                  TxFfFull;
    logic                  TxFfRdEn;
    logic [DATA_WIDTH-1:0] TxFfRdData;
    logic                  TxFfEmpty;
    logic [ADDR_WIDTH:0]   TxFfCount;
`ifdef TX_FIFO_ERR_FLAGS_EN
    logic                  TxFfErrClr;
    logic                  TxFfOvf;
    logic                  TxFfUdf;

    modport master (
        output TxFfWrEn, TxFfWrData, TxFfRdEn, TxFfErrClr,
        input  TxFfFull, TxFfRdData, TxFfEmpty, TxFfCount, TxFfOvf, TxFfUdf
    );
    modport slave (
        input  TxFfWrEn, TxFfWrData, TxFfRdEn, TxFfErrClr,
        output TxFfFull, TxFfRdData, TxFfEmpty, TxFfCount, TxFfOvf, TxFfUdf
    );
`else
    modport master (
        output TxFfWrEn, TxFfWrData, TxFfRdEn,
        input  TxFfFull, TxFfRdData, TxFfEmpty, TxFfCount
    );
    modport slave (
        input  TxFfWrEn, TxFfWrData, TxFfRdEn,
        output TxFfFull, TxFfRdData, TxFfEmpty, TxFfCount
    );
`endif
endinterface

// File: rtl/tx_fifo.sv
// Single-clock byte FIFO feeding TxUART; optional sticky ovf/udf flags via TX_FIFO_ERR_FLAGS_EN.
// Latency: registered read data, visible the cycle after an accepted read; no fall-through.
// Backpressure: Full blocks writes (dropped), Empty blocks reads (RdData holds).
module tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic     Clk,
    input logic     RstB,
    tx_fifo_if.slave ffIf
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wrPtr;
    logic [ADDR_WIDTH:0]   rdPtr;
    logic [ADDR_WIDTH:0]   wrPtrNxt;
    logic [ADDR_WIDTH:0]   rdPtrNxt;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   countNxt;
    logic                  full;
    logic                  empty;
    logic                  fullNxt;
    logic                  emptyNxt;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  wrAccept;
    logic                  rdAccept;

    // Flags are registered, so acceptance always looks at last cycle's occupancy;
    // this is what makes write-on-empty and read-on-full resolve without fall-through.
    assign wrAccept = ffIf.TxFfWrEn && !full;
    assign rdAccept = ffIf.TxFfRdEn && !empty;

    always_comb begin
        wrPtrNxt = wrPtr;
        rdPtrNxt = rdPtr;
        countNxt = count;
        if (wrAccept) wrPtrNxt = wrPtr + PTR_ONE;
        if (rdAccept) rdPtrNxt = rdPtr + PTR_ONE;
        case ({wrAccept, rdAccept})
            2'b10:   countNxt = count + PTR_ONE;
            2'b01:   countNxt = count - PTR_ONE;
            default: countNxt = count;
        endcase
        emptyNxt = (wrPtrNxt == rdPtrNxt);
        fullNxt  = (wrPtrNxt[ADDR_WIDTH-1:0] == rdPtrNxt[ADDR_WIDTH-1:0]) &&
                   (wrPtrNxt[ADDR_WIDTH] != rdPtrNxt[ADDR_WIDTH]);
    end

    always_ff @(posedge Clk) begin
        if (RstB) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdData <= '0;
        end else begin
            wrPtr <= wrPtrNxt;
            rdPtr <= rdPtrNxt;
            count <= countNxt;
            empty <= emptyNxt;
            full  <= fullNxt;
            if (rdAccept) rdData <= mem[rdPtr[ADDR_WIDTH-1:0]];
        end
    end

    // Storage is deliberately not reset; pointer reset alone discards contents.
    always_ff @(posedge Clk) begin
        if (wrAccept && !RstB) mem[wrPtr[ADDR_WIDTH-1:0]] <= ffIf.TxFfWrData;
    end

    assign ffIf.TxFfFull   = full;
    assign ffIf.TxFfEmpty  = empty;
    assign ffIf.TxFfCount  = count;
    assign ffIf.TxFfRdData = rdData;

`ifdef TX_FIFO_ERR_FLAGS_EN
    logic ovf;
    logic udf;

    // Clear wins over a same-cycle set.
    always_ff @(posedge Clk) begin
        if (RstB || ffIf.TxFfErrClr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ffIf.TxFfWrEn && full)  ovf <= 1'b1;
            if (ffIf.TxFfRdEn && empty) udf <= 1'b1;
        end
    end

    assign ffIf.TxFfOvf = ovf;
    assign ffIf.TxFfUdf = udf;
`endif
endmodule
